// File: rtl/card_ram_sequencer.sv
// card_ram_sequencer: runs one asynchronous SRAM access per accepted CPU bus
// cycle (SETUP -> STROBE x WAIT_STATES -> LATCH -> RECOVER) and returns read
// data to the bus mux with a one-cycle valid pulse.
module card_ram_sequencer #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 3
) (
    input  logic              mclk28,
    input  logic              reset_in_n,
    input  logic              cpu_strobe,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic              card_ram_rd,
    input  logic              card_ram_we,
    input  logic              we,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              overrun,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    input  logic [DATA_W-1:0] sram_din,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam int CNT_W = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_LATCH,
        S_RECOVER
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dv_q, dv_d;
    logic              ovr_q, ovr_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic              accept;

    // Next-state, capture and strobe decode; SRAM controls are derived from
    // the next state so the pins are clean flop outputs aligned with the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        ovr_d   = ovr_q | (cpu_strobe & (state_q != S_IDLE));

        accept = (state_q == S_IDLE) && cpu_strobe &&
                 ((we && card_ram_we) || (!we && card_ram_rd));

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SETUP;
                    wr_d    = we;
                    addr_d  = ram_addr;
                    wdata_d = din;
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                cnt_d   = CNT_W'(WAIT_STATES - 1);
            end
            S_STROBE: begin
                if (cnt_q == '0) state_d = S_LATCH;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_LATCH: begin
                state_d = S_RECOVER;
                if (!wr_q) begin
                    dout_d = sram_din;
                    dv_d   = 1'b1;
                end
            end
            S_RECOVER: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        ce_n_d  = !(state_d == S_SETUP || state_d == S_STROBE || state_d == S_LATCH);
        oe_n_d  = !(state_d == S_STROBE && !wr_d);
        we_n_d  = !(state_d == S_STROBE && wr_d);
        dq_oe_d = wr_d && (state_d == S_SETUP || state_d == S_STROBE || state_d == S_LATCH);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge mclk28) begin
        if (!reset_in_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            ovr_q   <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            ovr_q   <= ovr_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            dq_oe_q <= dq_oe_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign overrun    = ovr_q;
    assign sram_addr  = addr_q;
    assign sram_dout  = wdata_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_dq_oe = dq_oe_q;

endmodule

// File: tb/tb_card_ram_sequencer.sv
// Bench for card_ram_sequencer: directed scenarios followed by random traffic,
// all checked against a cycle-count model of the access timeline.
module tb_card_ram_sequencer;

    localparam int WS = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_strobe, card_ram_rd, card_ram_we, we;
    logic [17:0] ram_addr;
    logic [7:0]  din, sram_din;
    logic [7:0]  dout, sram_dout;
    logic [17:0] sram_addr;
    logic        dout_valid, busy, overrun, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    int checks = 0;
    int failures = 0;

    // Model: k = cycles since the access was accepted (0 = idle).
    int          k = 0;
    bit          mwr = 0;
    logic [17:0] maddr = '0;
    logic [7:0]  mwd = '0, mdout = '0;
    bit          mdv = 0, movr = 0;

    card_ram_sequencer #(.ADDR_W(18), .DATA_W(8), .WAIT_STATES(WS)) dut (
        .mclk28(clk), .reset_in_n(rst_n), .cpu_strobe(cpu_strobe), .ram_addr(ram_addr),
        .card_ram_rd(card_ram_rd), .card_ram_we(card_ram_we), .we(we), .din(din),
        .dout(dout), .dout_valid(dout_valid), .busy(busy), .overrun(overrun),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model across one rising edge using the inputs held over it.
    task automatic model_edge();
        mdv = 0;
        if (!rst_n) begin
            k = 0; mwr = 0; maddr = '0; mwd = '0; mdout = '0; movr = 0;
        end else if (k != 0) begin
            if (cpu_strobe) movr = 1;
            if (k == WS + 2 && !mwr) begin
                mdout = sram_din;
                mdv   = 1;
            end
            k = (k == WS + 3) ? 0 : k + 1;
        end else if (cpu_strobe && ((we && card_ram_we) || (!we && card_ram_rd))) begin
            k = 1; mwr = we; maddr = ram_addr; mwd = din;
        end
    endtask

    task automatic compare_all();
        bit in_ce, in_strb;
        in_ce   = (k >= 1) && (k <= WS + 2);
        in_strb = (k >= 2) && (k <= WS + 1);
        chk("busy",      busy,       k != 0);
        chk("ce_n",      sram_ce_n,  !in_ce);
        chk("oe_n",      sram_oe_n,  !(in_strb && !mwr));
        chk("we_n",      sram_we_n,  !(in_strb && mwr));
        chk("dq_oe",     sram_dq_oe, in_ce && mwr);
        chk("sram_addr", sram_addr,  maddr);
        chk("sram_dout", sram_dout,  mwd);
        chk("dout",      dout,       mdout);
        chk("dout_vld",  dout_valid, mdv);
        chk("overrun",   overrun,    movr);
        chk("oe_we_excl", !sram_oe_n && !sram_we_n, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
    endtask

    task automatic set_req(input bit s, input bit w, input bit rd, input bit wen,
                           input logic [17:0] a, input logic [7:0] d);
        cpu_strobe = s; we = w; card_ram_rd = rd; card_ram_we = wen; ram_addr = a; din = d;
    endtask

    initial begin
        int oe_cnt, we_cnt, dv_cnt;
        rst_n = 0; sram_din = 8'h00;
        set_req(0, 0, 0, 0, '0, '0);

        // 1: reset held two cycles then released
        tick(); tick();
        rst_n = 1;
        tick();
        chk("t1_ce_n", sram_ce_n, 1'b1);
        chk("t1_busy", busy, 1'b0);

        // 2: read of 1D123 returning A5
        sram_din = 8'hA5;
        set_req(1, 0, 1, 0, 18'h1D123, 8'h33);
        tick();
        chk("t2_addr", sram_addr, 18'h1D123);
        cpu_strobe = 0; ram_addr = 18'h00001;
        oe_cnt = (sram_oe_n == 0) ? 1 : 0;
        for (int i = 2; i <= 6; i++) begin
            tick();
            if (sram_oe_n == 0) oe_cnt++;
            if (i == 5) chk("t2_noval_early", dout_valid, 1'b0);
            if (i == 6) begin
                chk("t2_dout", dout, 8'hA5);
                chk("t2_dvalid", dout_valid, 1'b1);
            end
        end
        chk("t2_oe_cycles", oe_cnt, 3);
        tick();
        chk("t2_dvalid_once", dout_valid, 1'b0);

        // 3: write of 5A to 00C00
        set_req(1, 1, 0, 1, 18'h00C00, 8'h5A);
        tick();
        set_req(0, 0, 0, 0, 18'h3FFFF, 8'hFF);
        we_cnt = 0; dv_cnt = 0;
        for (int i = 2; i <= 7; i++) begin
            tick();
            if (sram_we_n == 0) we_cnt++;
            if (dout_valid) dv_cnt++;
            if (i == 5) chk("t3_dq_latch", sram_dq_oe, 1'b1);
            if (i == 6) chk("t3_dq_recover", sram_dq_oe, 1'b0);
        end
        chk("t3_we_cycles", we_cnt, 3);
        chk("t3_no_dvalid", dv_cnt, 0);
        chk("t3_wdata", sram_dout, 8'h5A);

        // 4: write to a write-protected card is ignored
        set_req(1, 1, 1, 0, 18'h01234, 8'h77);
        tick();
        cpu_strobe = 0;
        chk("t4_busy", busy, 1'b0);
        chk("t4_ce_n", sram_ce_n, 1'b1);
        tick();

        // 5: overrun during a read; back-to-back strobe after RECOVER
        sram_din = 8'h3C;
        set_req(1, 0, 1, 0, 18'h20000 - 1, 8'h00);
        tick();
        cpu_strobe = 0;
        for (int i = 2; i <= 6; i++) begin
            cpu_strobe = (i == 3);
            ram_addr   = 18'h15555;
            tick();
        end
        chk("t5_overrun", overrun, 1'b1);
        chk("t5_dout", dout, 8'h3C);
        cpu_strobe = 0;
        tick();
        chk("t5_idle", busy, 1'b0);
        set_req(1, 0, 1, 0, 18'h0ABCD, 8'h00);
        tick();
        cpu_strobe = 0;
        chk("t5_b2b_busy", busy, 1'b1);
        for (int i = 0; i < 6; i++) tick();

        // 6: reset during a write's STROBE phase
        set_req(1, 1, 0, 1, 18'h00777, 8'hC3);
        tick();
        cpu_strobe = 0;
        tick();
        chk("t6_we_low", sram_we_n, 1'b0);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("t6_we_n", sram_we_n, 1'b1);
        chk("t6_ce_n", sram_ce_n, 1'b1);
        chk("t6_dq_oe", sram_dq_oe, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_overrun", overrun, 1'b0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            cpu_strobe  = ($urandom_range(0, 3) == 0);
            we          = $urandom_range(0, 1) == 1;
            card_ram_rd = $urandom_range(0, 3) != 0;
            card_ram_we = $urandom_range(0, 3) != 0;
            ram_addr    = 18'($urandom);
            din         = 8'($urandom);
            sram_din    = 8'($urandom);
            rst_n       = ($urandom_range(0, 149) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
